// File: rtl/note_draw_scheduler.sv
// rtl/note_draw_scheduler.sv - note-request FIFO and draw/clear sequencer for the VGA note drawer
module note_draw_scheduler #(
  parameter int DEPTH       = 4,
  parameter int NOTE_CYCLES = 436,
  parameter int CLR_CYCLES  = 19520,
  parameter int X0          = 8,
  parameter int Y0          = 50,
  parameter int SLOT_PITCH  = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_note,
  input  logic [1:0] req_octave,
  input  logic [1:0] req_slot,
  input  logic       clr_req,
  output logic [3:0] note_out,
  output logic [1:0] octave_out,
  output logic [7:0] x_base,
  output logic [6:0] y_base,
  output logic       ld_note,
  output logic       clear_n,
  output logic       busy,
  output logic       done,
  output logic [2:0] fifo_count
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_DRAW, S_GAP} state_t;

  state_t        state, next_state;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [2:0]    count;
  logic          clr_pending;
  logic [14:0]   draw_cnt, clr_cnt;
  logic [7:0]    head;
  logic [7:0]    slot_x;
  logic          wr_en, pop, enter_clear;

  assign req_ready   = (count < 3'(DEPTH));
  assign fifo_count  = count;
  // Invalid note codes still complete the handshake but never reach storage.
  assign wr_en       = req_valid && req_ready && (req_note >= 4'd1) && (req_note <= 4'd12);
  assign head        = mem[rd_ptr];
  assign slot_x      = 8'(X0 + SLOT_PITCH * int'(head[1:0]));
  assign pop         = (state == S_IDLE) && !clr_pending && (count != 3'd0);
  assign enter_clear = (state == S_IDLE) && clr_pending;

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (clr_pending)          next_state = S_CLEAR;
        else if (count != 3'd0)   next_state = S_LOAD;
      end
      S_CLEAR: if (clr_cnt == 15'd0)  next_state = S_GAP;
      S_LOAD:                         next_state = S_DRAW;
      S_DRAW:  if (draw_cnt == 15'd0) next_state = S_GAP;
      S_GAP:                          next_state = S_IDLE;
      default:                        next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {req_note, req_octave, req_slot};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= 3'd0;
      clr_pending <= 1'b0;
      draw_cnt    <= 15'd0;
      clr_cnt     <= 15'd0;
      ld_note     <= 1'b0;
      clear_n     <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      note_out    <= 4'd0;
      octave_out  <= 2'd0;
      x_base      <= 8'd0;
      y_base      <= 7'd0;
    end else begin
      state       <= next_state;
      ld_note     <= (next_state == S_DRAW);
      clear_n     <= (next_state != S_CLEAR);
      busy        <= (next_state != S_IDLE);
      done        <= (next_state == S_GAP);
      clr_pending <= clr_req | (clr_pending & ~enter_clear);

      // A flush keeps only a request pushed in the very cycle the clear starts.
      if (enter_clear) begin
        rd_ptr <= wr_ptr;
        count  <= wr_en ? 3'd1 : 3'd0;
      end else begin
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + {2'b00, wr_en} - {2'b00, pop};
      end
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);

      if (pop) begin
        note_out   <= head[7:4];
        octave_out <= head[3:2];
        x_base     <= slot_x;
        y_base     <= 7'(Y0);
      end

      // Separate down-counters so a clear window can never inherit draw time.
      if (state != S_DRAW && next_state == S_DRAW) draw_cnt <= 15'(NOTE_CYCLES - 1);
      else if (state == S_DRAW)                     draw_cnt <= draw_cnt - 15'd1;
      if (state != S_CLEAR && next_state == S_CLEAR) clr_cnt <= 15'(CLR_CYCLES - 1);
      else if (state == S_CLEAR)                      clr_cnt <= clr_cnt - 15'd1;
    end
  end
endmodule

// File: tb/tb_note_draw_scheduler.sv
// tb/tb_note_draw_scheduler.sv - directed scoreboard bench for note_draw_scheduler
module tb_note_draw_scheduler;
  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready, clr_req;
  logic [3:0] req_note;
  logic [1:0] req_octave, req_slot;
  logic [3:0] note_out;
  logic [1:0] octave_out;
  logic [7:0] x_base;
  logic [6:0] y_base;
  logic       ld_note, clear_n, busy, done;
  logic [2:0] fifo_count;

  typedef struct {
    logic [3:0] n;
    logic [1:0] o;
    logic [7:0] x;
  } exp_t;

  exp_t sb[$];
  int   rise_q[$];
  int   checks = 0, errors = 0;
  int   cyc = 0;
  int   done_cnt = 0, done_cyc = 0, hi_len = 0, clr_len = 0;
  logic prev_ld = 1'b0, prev_clr = 1'b1;

  note_draw_scheduler dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_note(req_note), .req_octave(req_octave), .req_slot(req_slot), .clr_req(clr_req),
    .note_out(note_out), .octave_out(octave_out), .x_base(x_base), .y_base(y_base),
    .ld_note(ld_note), .clear_n(clear_n), .busy(busy), .done(done), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Monitor: pop scoreboard on every ld_note rise, measure windows, count done pulses.
  always @(negedge clk) begin
    if (reset) begin
      prev_ld = 1'b0; prev_clr = 1'b1; hi_len = 0; clr_len = 0;
    end else begin
      check("ld_clr_overlap", {31'd0, ld_note & ~clear_n}, 0);
      if (ld_note && !prev_ld) begin
        rise_q.push_back(cyc);
        check("sb_nonempty_at_draw", {31'd0, sb.size() != 0}, 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("note_out", {28'd0, note_out}, {28'd0, e.n});
          check("octave_out", {30'd0, octave_out}, {30'd0, e.o});
          check("x_base", {24'd0, x_base}, {24'd0, e.x});
          check("y_base", {25'd0, y_base}, 50);
        end
        hi_len = 0;
      end
      if (ld_note) hi_len++;
      if (!ld_note && prev_ld) check("ld_window_len", hi_len, 436);
      if (!clear_n && prev_clr) clr_len = 0;
      if (!clear_n) clr_len++;
      if (clear_n && !prev_clr) check("clear_window_len", clr_len, 19520);
      if (done) begin done_cnt++; done_cyc = cyc; end
      prev_ld = ld_note;
      prev_clr = clear_n;
    end
  end

  // Drives one request at the current time (just after a posedge) and returns whether it was taken.
  task automatic push(input logic [3:0] n, input logic [1:0] o, input logic [1:0] s, output logic acc);
    exp_t e;
    req_valid = 1'b1; req_note = n; req_octave = o; req_slot = s;
    @(negedge clk);
    acc = req_ready;
    if (acc && n >= 4'd1 && n <= 4'd12) begin
      e.n = n; e.o = o; e.x = 8'(8 + 40 * int'(s));
      sb.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rise(input int start_cnt, input string tag);
    for (int i = 0; i < 2000 && rise_q.size() == start_cnt; i++) @(negedge clk);
    check(tag, {31'd0, rise_q.size() > start_cnt}, 1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && fifo_count == 3'd0) break;
    end
    check(tag, {31'd0, busy}, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic acc;
    int   p, r0, d0;
    reset = 1'b1; req_valid = 1'b0; clr_req = 1'b0;
    req_note = 4'd0; req_octave = 2'd0; req_slot = 2'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // 1. idle after reset
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 1);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_ld_note", {31'd0, ld_note}, 0);
    check("rst_clear_n", {31'd0, clear_n}, 1);
    check("rst_fifo_count", {29'd0, fifo_count}, 0);
    check("rst_note_out", {28'd0, note_out}, 0);
    check("rst_x_base", {24'd0, x_base}, 0);
    repeat (100) @(negedge clk);
    check("idle_no_done", done_cnt, 0);
    @(posedge clk); #1;

    // 2. single note: latency, window, position, done
    d0 = done_cnt; r0 = rise_q.size(); p = cyc;
    push(4'd5, 2'd2, 2'd1, acc);
    check("single_accept", {31'd0, acc}, 1);
    wait_rise(r0, "single_rise_seen");
    check("single_latency", rise_q[$] - p, 3);
    wait_idle(1000, "single_idle");
    check("single_done_count", done_cnt - d0, 1);
    check("single_done_at_gap", done_cyc - rise_q[$], 436);

    // 3. back-to-back: one in DRAW, five pushes, four fit
    r0 = rise_q.size(); d0 = done_cnt;
    push(4'd1, 2'd0, 2'd0, acc);
    wait_rise(r0, "b2b_first_rise");
    @(posedge clk); #1;
    push(4'd2, 2'd1, 2'd1, acc);  check("b2b_acc0", {31'd0, acc}, 1);
    push(4'd3, 2'd2, 2'd2, acc);  check("b2b_acc1", {31'd0, acc}, 1);
    push(4'd4, 2'd3, 2'd3, acc);  check("b2b_acc2", {31'd0, acc}, 1);
    push(4'd12, 2'd0, 2'd2, acc); check("b2b_acc3", {31'd0, acc}, 1);
    check("b2b_full_count", {29'd0, fifo_count}, 4);
    check("b2b_full_ready", {31'd0, req_ready}, 0);
    push(4'd7, 2'd1, 2'd0, acc);  check("b2b_acc4_rejected", {31'd0, acc}, 0);
    wait_idle(3000, "b2b_idle");
    check("b2b_draw_count", rise_q.size() - r0, 5);
    for (int i = r0; i + 1 < rise_q.size(); i++)
      check("b2b_rise_spacing", rise_q[i + 1] - rise_q[i], 439);
    check("b2b_done_count", done_cnt - d0, 5);
    check("b2b_sb_drained", sb.size(), 0);

    // 4. clear priority over queued notes
    r0 = rise_q.size(); d0 = done_cnt;
    push(4'd6, 2'd1, 2'd2, acc);
    wait_rise(r0, "clr_first_rise");
    @(posedge clk); #1;
    push(4'd8, 2'd2, 2'd0, acc);
    push(4'd9, 2'd3, 2'd1, acc);
    check("clr_queued", {29'd0, fifo_count}, 2);
    clr_req = 1'b1; @(posedge clk); #1 clr_req = 1'b0;
    for (int i = 0; i < 1000 && clear_n; i++) @(negedge clk);
    check("clr_entered", {31'd0, clear_n}, 0);
    check("clr_after_draw", {31'd0, rise_q.size() - r0 == 1 && !ld_note}, 1);
    check("clr_flushed", {29'd0, fifo_count}, 0);
    sb.delete();
    wait_idle(21000, "clr_idle");
    check("clr_no_queued_draw", rise_q.size() - r0, 1);
    check("clr_done_count", done_cnt - d0, 2);

    // 5. invalid notes are dropped
    r0 = rise_q.size(); d0 = done_cnt;
    push(4'd0, 2'd1, 2'd1, acc);  check("inv0_handshake", {31'd0, acc}, 1);
    push(4'd13, 2'd1, 2'd1, acc); check("inv13_handshake", {31'd0, acc}, 1);
    check("inv_count", {29'd0, fifo_count}, 0);
    repeat (20) @(negedge clk);
    check("inv_no_draw", rise_q.size() - r0, 0);
    check("inv_no_done", done_cnt - d0, 0);
    @(posedge clk); #1;

    // 6. reset in the middle of a draw
    r0 = rise_q.size();
    push(4'd10, 2'd0, 2'd3, acc);
    wait_rise(r0, "mid_rise");
    @(posedge clk); #1;
    push(4'd11, 2'd1, 2'd1, acc);
    repeat (197) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("mid_ld_note", {31'd0, ld_note}, 0);
    check("mid_fifo_count", {29'd0, fifo_count}, 0);
    check("mid_busy", {31'd0, busy}, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    r0 = rise_q.size(); d0 = done_cnt; p = cyc;
    push(4'd3, 2'd3, 2'd3, acc);
    wait_rise(r0, "post_rst_rise");
    check("post_rst_latency", rise_q[$] - p, 3);
    wait_idle(1000, "post_rst_idle");
    check("post_rst_done", done_cnt - d0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
